// File: rtl/mem_word_bridge.sv
// mem_word_bridge
//   Converts 32-bit word read/write requests into four sequential byte
//   accesses on the memctl byte port, returning one response per request.
//   Byte k of a word lives at addr+k and in data[8k+7:8k] (little-endian).
//   This block is the only master of memctl.
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_write        1 = write, 0 = read
//   req_addr         word byte-address, must be 4-aligned and in range
//   req_wdata/be     write data and per-byte enables (be ignored on reads)
//   rsp_valid/ready  response handshake, response held until accepted
//   rsp_rdata        read data (0 for writes and errors)
//   rsp_err          misaligned or out-of-range request
//   mem_addr         byte address to memctl
//   mem_wdata        byte write data to memctl
//   mem_write_en     byte write strobe to memctl
//   mem_rdata        registered read byte from memctl (one cycle after mem_addr)
module mem_word_bridge #(
  parameter int MEM_BYTES = 65536,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_write_en,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        k;
  logic [1:0]        k_nxt;

  // Request context, captured on the accept edge only.
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              err;
  logic [31:0]       rdata;

  logic              accept;
  logic              req_bad;

  // Misaligned, or the last byte of the word lies beyond the store. The sum
  // is formed 32 bits wide so the check itself cannot wrap.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [31:0] last;
    last = 32'(a) + 32'd3;
    return (a[1:0] != 2'b00) || (last > 32'(MEM_BYTES - 1));
  endfunction

  assign accept  = (state == IDLE) && req_valid;
  assign req_bad = addr_bad(req_addr);

  // Control state: the only registers that reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= 2'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    unique case (state)
      IDLE: begin
        k_nxt = 2'd0;
        if (req_valid) begin
          if (req_bad)        state_nxt = RESP;
          else if (req_write) state_nxt = WR;
          else                state_nxt = RD;
        end
      end
      WR: begin
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = RESP;
      end
      RD: begin
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath capture. The read buffer is cleared on accept so writes and
  // errors report zero data; read bytes arrive one cycle behind their address.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr  <= req_addr;
      wdata <= req_wdata;
      be    <= req_be;
      err   <= req_bad;
      rdata <= 32'd0;
    end else if (state == RD && k != 2'd0) begin
      rdata[{k - 2'd1, 3'b000} +: 8] <= mem_rdata;
    end else if (state == DRAIN) begin
      rdata[31:24] <= mem_rdata;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready    = (state == IDLE);
    rsp_valid    = (state == RESP);
    rsp_rdata    = 32'd0;
    rsp_err      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 8'd0;
    mem_write_en = 1'b0;
    if (state == RESP) begin
      rsp_rdata = rdata;
      rsp_err   = err;
    end
    if (state == WR) begin
      mem_addr     = addr + ADDR_W'(k);
      mem_wdata    = wdata[{k, 3'b000} +: 8];
      mem_write_en = be[k];
    end else if (state == RD) begin
      mem_addr = addr + ADDR_W'(k);
    end
  end

endmodule

// File: tb/tb_mem_word_bridge.sv
// tb_mem_word_bridge
//   Bench for mem_word_bridge with a behavioural memctl byte store attached.
//   Expected responses are queued when each request is issued and checked
//   when the response appears.
module tb_mem_word_bridge;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_write_en;
  logic [7:0]        mem_rdata;

  always #5 clk = ~clk;

  mem_word_bridge #(.MEM_BYTES(65536), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata)
  );

  // memctl stand-in: byte store with registered read.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;
  logic [7:0] mem [0:65535];
  wr_t        wlog[$];
  int         we_cnt = 0;

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_addr[15:0]] <= mem_wdata;
      wlog.push_back('{mem_addr, mem_wdata});
    end
    mem_rdata <= mem[mem_addr[15:0]];
  end

  always @(negedge clk) if (mem_write_en) we_cnt++;

  // Reference contents and scoreboard.
  logic [7:0] refm [0:65535];
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic transact(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input int hold, input string tag,
                          output logic [31:0] rd);
    exp_t        e;
    exp_t        got_e;
    logic        bad;
    int          lat;
    int          we0;
    logic [31:0] r0;
    logic        stable;
    bad     = (a[1:0] != 2'b00) || ((32'(a) + 32'd3) > 32'd65535);
    e.err   = bad;
    e.rdata = 32'd0;
    e.lat   = bad ? 1 : (wr ? 5 : 6);
    e.nwe   = 0;
    if (!bad) begin
      for (int i = 0; i < 4; i++) begin
        if (wr && b[i]) begin
          refm[a + ADDR_W'(i)] = d[8*i +: 8];
          e.nwe++;
        end
        if (!wr) e.rdata[8*i +: 8] = refm[a + ADDR_W'(i)];
      end
    end
    sb.push_back(e);

    @(negedge clk);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_be    = b;
    we0       = we_cnt;
    @(posedge clk);
    #1;
    // Busy-time input changes must be ignored.
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ADDR_W'($urandom);
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got_e = sb.pop_front();
    chk({tag, "_lat"},   64'(lat),          64'(got_e.lat));
    chk({tag, "_rdata"}, 64'(rsp_rdata),    64'(got_e.rdata));
    chk({tag, "_err"},   64'(rsp_err),      64'(got_e.err));
    chk({tag, "_nwe"},   64'(we_cnt - we0), 64'(got_e.nwe));
    rd = rsp_rdata;

    if (hold > 0) begin
      r0     = rsp_rdata;
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!rsp_valid || rsp_rdata !== r0 || req_ready) stable = 1'b0;
      end
      chk({tag, "_hold"}, 64'(stable), 64'd1);
    end

    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          idx;
    int          we0;
    logic [7:0]  exp_b [4];

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready),    64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid),    64'd0);
    chk("rst_rsp_err",   64'(rsp_err),      64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata),    64'd0);
    chk("rst_mem_addr",  64'(mem_addr),     64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata),    64'd0);
    chk("rst_mem_we",    64'(mem_write_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full word write, byte order on the memctl port.
    idx = wlog.size();
    transact(1'b1, 17'h00100, 32'hDEADBEEF, 4'hF, 0, "wr1", rd);
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk("wr1_log_len", 64'(wlog.size() - idx), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (idx + i < wlog.size()) begin
        chk($sformatf("wr1_log_addr%0d", i), 64'(wlog[idx+i].a), 64'(17'h00100 + 17'(i)));
        chk($sformatf("wr1_log_data%0d", i), 64'(wlog[idx+i].d), 64'(exp_b[i]));
      end
    end

    transact(1'b0, 17'h00100, 32'd0, 4'h0, 0, "rd1", rd);
    chk("rd1_word", 64'(rd), 64'hDEADBEEF);

    // Partial byte enables, then read back with a stalled consumer.
    transact(1'b1, 17'h00100, 32'h11223344, 4'b0101, 0, "wr_be", rd);
    transact(1'b0, 17'h00100, 32'd0, 4'h0, 10, "rd_be", rd);
    chk("rd_be_word", 64'(rd), 64'hDE22BE44);

    // Error requests.
    transact(1'b0, 17'h00102, 32'd0, 4'h0, 0, "err_mis", rd);
    transact(1'b0, 17'h0FFFE, 32'd0, 4'h0, 0, "err_rng", rd);
    transact(1'b0, 17'h10000, 32'd0, 4'h0, 0, "err_oob", rd);
    transact(1'b1, 17'h00101, 32'h12345678, 4'hF, 0, "err_wr", rd);

    // Last valid word of the store.
    transact(1'b1, 17'h0FFFC, 32'hCAFEF00D, 4'hF, 0, "wr_top", rd);
    transact(1'b0, 17'h0FFFC, 32'd0, 4'h0, 0, "rd_top", rd);
    chk("rd_top_word", 64'(rd), 64'hCAFEF00D);

    // Reset in the middle of a write: sampled on the edge that would start lane 2.
    transact(1'b1, 17'h00200, 32'h55667788, 4'hF, 0, "wr_pre", rd);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 17'h00200;
    req_wdata = 32'hAABBCCDD;
    req_be    = 4'hF;
    we0       = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_we",        64'(mem_write_en), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid),    64'd0);
    chk("mid_rst_req_ready", 64'(req_ready),    64'd1);
    chk("mid_rst_mem_addr",  64'(mem_addr),     64'd0);
    chk("mid_rst_nwe",       64'(we_cnt - we0), 64'd2);
    refm[17'h00200] = 8'hDD;
    refm[17'h00201] = 8'hCC;
    transact(1'b0, 17'h00200, 32'd0, 4'h0, 0, "rd_post_rst", rd);
    chk("rd_post_rst_word", 64'(rd), 64'h5566CCDD);

    // Randomised traffic on a scratch region.
    for (int i = 0; i < 8; i++) begin
      logic [ADDR_W-1:0] a;
      a = 17'h00300 + ADDR_W'(4 * i);
      transact(1'b1, a, $urandom, 4'hF, 0, $sformatf("rnd_full%0d", i), rd);
      transact(1'b1, a, $urandom, 4'($urandom), 0, $sformatf("rnd_part%0d", i), rd);
      transact(1'b0, a, 32'd0, 4'h0, $urandom_range(0, 3), $sformatf("rnd_rd%0d", i), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
